fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the 5-stage pipelined MIPS CPU.
- Owns the PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Registers the fetched instruction, PC and PC+4 into the decode stage, where the controller decodes instr[31:26] and instr[5:0].
- Applies stall and redirect requests from the hazard unit and the D-stage branch/jump logic.

---
 rtl/cpu_defs_pkg.sv | 12 +
 rtl/fetch_stage_if.sv | 11 +
 rtl/flopenrc.sv | 26 ++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared widths and constants for the pipelined MIPS core.
package cpu_defs_pkg;
    localparam int          INSTR_W          = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: fetch stage is master, synchronous-read RAM is slave.
interface fetch_stage_if;
    import cpu_defs_pkg::*;

    logic               inst_ram_ena;
    logic [PC_W-1:0]    inst_addr;
    logic [INSTR_W-1:0] inst_rdata;

    modport master (output inst_ram_ena, output inst_addr, input  inst_rdata);
    modport slave  (input  inst_ram_ena, input  inst_addr, output inst_rdata);
endinterface

// File: rtl/flopenrc.sv
// Flip-flop with synchronous reset, enable and clear; enable gates the clear.
module flopenrc #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset beats everything; a held stage ignores clear as well as load.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (en) begin
            if (clr)
                q <= '0;
            else
                q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, next-PC select, imem address,
// stall/flush handling into decode.
module fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              DELAY_SLOT = 0
) (
    input  logic               clka,
    input  logic               rst,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               pcsrcD,
    input  logic               jumpD,
    input  logic [PC_W-1:0]    pcbranchD,
    input  logic [PC_W-1:0]    pcjumpD,
    fetch_stage_if.master      imem,
    output logic [PC_W-1:0]    pcF,
    output logic [INSTR_W-1:0] instrD,
    output logic [PC_W-1:0]    pcD,
    output logic [PC_W-1:0]    pcplus4D,
    output logic               validD
);

    // Without a delay slot the instruction fetched alongside a redirect is wrong-path.
    localparam logic SQUASH = (DELAY_SLOT == 0);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_plus4;
    logic               flush_d;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_id_q;
    logic [PC_W-1:0]    pcplus4_id_q;
    logic               valid_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign flush_d  = (jumpD | pcsrcD) & SQUASH;

    // Next-PC priority: stall hold, jump, branch, sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (stallF)
            pc_d = pc_q;
        else if (jumpD)
            pc_d = pcjumpD;
        else if (pcsrcD)
            pc_d = pcbranchD;
        pc_d = word_align(pc_d);
    end

    // Present next PC to the RAM so its data lines up with pc_q after the edge.
    always_comb begin
        imem.inst_ram_ena = 1'b1;
        imem.inst_addr    = rst ? RESET_PC : pc_d;
    end

    flopenrc #(.WIDTH(PC_W), .RST_VAL(RESET_PC)) u_pc (
        .clk (clka), .rst (rst), .en (~stallF), .clr (1'b0),
        .d   (pc_d), .q   (pc_q)
    );

    flopenrc #(.WIDTH(INSTR_W), .RST_VAL(NOP_INSTR)) u_instr_d (
        .clk (clka), .rst (rst), .en (~stallD), .clr (flush_d),
        .d   (imem.inst_rdata), .q (instr_q)
    );

    flopenrc #(.WIDTH(PC_W)) u_pc_d (
        .clk (clka), .rst (rst), .en (~stallD), .clr (flush_d),
        .d   (pc_q), .q (pc_id_q)
    );

    flopenrc #(.WIDTH(PC_W)) u_pcplus4_d (
        .clk (clka), .rst (rst), .en (~stallD), .clr (flush_d),
        .d   (pc_plus4), .q (pcplus4_id_q)
    );

    flopenrc #(.WIDTH(1)) u_valid_d (
        .clk (clka), .rst (rst), .en (~stallD), .clr (flush_d),
        .d   (1'b1), .q (valid_q)
    );

    assign pcF      = pc_q;
    assign instrD   = instr_q;
    assign pcD      = pc_id_q;
    assign pcplus4D = pcplus4_id_q;
    assign validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench: two fetch stages (no delay slot / delay slot) on shared stimulus.
module tb_fetch_stage;
    import cpu_defs_pkg::*;

    logic        clka = 1'b0;
    logic        rst;
    logic        stallF, stallD, pcsrcD, jumpD;
    logic [31:0] pcbranchD, pcjumpD;

    logic [31:0] pcF0, instrD0, pcD0, pcplus4D0;
    logic [31:0] pcF1, instrD1, pcD1, pcplus4D1;
    logic        validD0, validD1;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage_if imem0 ();
    fetch_stage_if imem1 ();

    always #5 clka = ~clka;

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(0)) u_dut0 (
        .clka(clka), .rst(rst), .stallF(stallF), .stallD(stallD),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .imem(imem0.master), .pcF(pcF0), .instrD(instrD0), .pcD(pcD0),
        .pcplus4D(pcplus4D0), .validD(validD0)
    );

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1)) u_dut1 (
        .clka(clka), .rst(rst), .stallF(stallF), .stallD(stallD),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .imem(imem1.master), .pcF(pcF1), .instrD(instrD1), .pcD(pcD1),
        .pcplus4D(pcplus4D1), .validD(validD1)
    );

    // Memory word at byte address a is 0x1000_0000 + a/4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clka) begin
        imem0.inst_rdata <= mem_word(imem0.inst_addr);
        imem1.inst_rdata <= mem_word(imem1.inst_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Check the D-stage fields of one DUT.
    task automatic check_d(input string tag, input int which, input logic [31:0] ins,
                           input logic [31:0] pc, input logic v);
        if (which == 0) begin
            check({tag, ".instrD0"}, instrD0, ins);
            check({tag, ".pcD0"}, pcD0, pc);
            check({tag, ".pcplus4D0"}, pcplus4D0, (v ? pc + 32'd4 : 32'h0));
            check({tag, ".validD0"}, {31'h0, validD0}, {31'h0, v});
        end else begin
            check({tag, ".instrD1"}, instrD1, ins);
            check({tag, ".pcD1"}, pcD1, pc);
            check({tag, ".pcplus4D1"}, pcplus4D1, (v ? pc + 32'd4 : 32'h0));
            check({tag, ".validD1"}, {31'h0, validD1}, {31'h0, v});
        end
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        check({tag, ".pcF0"}, pcF0, exp);
        check({tag, ".pcF1"}, pcF1, exp);
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
        pcbranchD = 32'h0; pcjumpD = 32'h0;

        // Reset state and reset-time memory request.
        step();
        step();
        check("rst_addr", imem0.inst_addr, 32'h0);
        check("rst_ena", {31'h0, imem0.inst_ram_ena}, 32'h1);
        check_pc("rst", 32'h0);
        check_d("rst", 0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("run_addr", imem0.inst_addr, 32'h4);

        // Free run.
        step();
        check_pc("run1", 32'h4);
        check_d("run1", 0, 32'h1000_0000, 32'h0, 1'b1);
        step();
        check_pc("run2", 32'h8);
        check_d("run2", 0, 32'h1000_0001, 32'h4, 1'b1);

        // Three-cycle stall at pcF=8.
        stallF = 1'b1; stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc("stall", 32'h8);
            check("stall_addr", imem0.inst_addr, 32'h8);
            check("stall_ena", {31'h0, imem0.inst_ram_ena}, 32'h1);
            check_d("stall", 0, 32'h1000_0001, 32'h4, 1'b1);
        end
        stallF = 1'b0; stallD = 1'b0;
        step();
        check_pc("resume1", 32'hC);
        check_d("resume1", 0, 32'h1000_0002, 32'h8, 1'b1);
        step();
        check_pc("resume2", 32'h10);
        check_d("resume2", 0, 32'h1000_0003, 32'hC, 1'b1);

        // Taken branch at pcF=0x10.
        pcsrcD = 1'b1; pcbranchD = 32'h40;
        step();
        pcsrcD = 1'b0;
        check_pc("br", 32'h40);
        check_d("br_squash", 0, 32'h0, 32'h0, 1'b0);
        check_d("br_slot", 1, 32'h1000_0004, 32'h10, 1'b1);
        step();
        check_pc("br_tgt", 32'h44);
        check_d("br_tgt", 0, 32'h1000_0010, 32'h40, 1'b1);
        check_d("br_tgt", 1, 32'h1000_0010, 32'h40, 1'b1);

        // Jump and branch together: jump wins.
        jumpD = 1'b1; pcjumpD = 32'h80; pcsrcD = 1'b1; pcbranchD = 32'h40;
        step();
        jumpD = 1'b0; pcsrcD = 1'b0;
        check_pc("jmp", 32'h80);
        check_d("jmp_squash", 0, 32'h0, 32'h0, 1'b0);
        check_d("jmp_slot", 1, 32'h1000_0011, 32'h44, 1'b1);
        step();
        check_pc("jmp_tgt", 32'h84);
        check_d("jmp_tgt", 0, 32'h1000_0020, 32'h80, 1'b1);

        // Redirect under stall is ignored.
        stallF = 1'b1; stallD = 1'b1; jumpD = 1'b1; pcjumpD = 32'h200;
        step();
        check_pc("stall_jmp", 32'h84);
        check_d("stall_jmp", 0, 32'h1000_0020, 32'h80, 1'b1);

        // Reset during stall with valid D.
        rst = 1'b1;
        step();
        check_pc("rst_stall", 32'h0);
        check_d("rst_stall", 0, 32'h0, 32'h0, 1'b0);
        check_d("rst_stall", 1, 32'h0, 32'h0, 1'b0);
        rst = 1'b0; stallF = 1'b0; stallD = 1'b0; jumpD = 1'b0;
        step();
        check_pc("post_rst", 32'h4);
        check_d("post_rst", 0, 32'h1000_0000, 32'h0, 1'b1);

        // Misaligned branch target is word aligned.
        pcsrcD = 1'b1; pcbranchD = 32'h43;
        step();
        pcsrcD = 1'b0;
        check_pc("align", 32'h40);

        // Wrap from the top of the address space.
        jumpD = 1'b1; pcjumpD = 32'hFFFF_FFFC;
        step();
        jumpD = 1'b0;
        check_pc("top", 32'hFFFF_FFFC);
        step();
        check_pc("wrap", 32'h0);
        check_d("wrap", 0, 32'h4FFF_FFFF, 32'hFFFF_FFFC, 1'b1);
        check("wrap_pcplus4D", pcplus4D0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
